// File: rtl/mem_burst_pkg.sv
// Shared types and defaults for the burst memory controller.
// Build option: BURST_WRAP_EN enables address wrap-around bursts.
package mem_burst_pkg;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_DEPTH  = 64;
    localparam int FIFO_DEPTH = 2;
    localparam int FIFO_PTR_W = $clog2(FIFO_DEPTH);
    localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        WR,
        RD,
        RD_DRAIN
    } state_e;

endpackage

// File: rtl/mem_rd_fifo.sv
// Small read-data FIFO between the memory read port and the consumer.
// Pop on empty is ignored; push and pop together keep occupancy.
module mem_rd_fifo
    import mem_burst_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_i,
    input  logic [WIDTH-1:0]      data_i,
    input  logic                  pop_i,
    output logic                  valid_o,
    output logic [WIDTH-1:0]      data_o,
    output logic [FIFO_CNT_W-1:0] count_o
);

    logic [WIDTH-1:0]      mem_q [FIFO_DEPTH];
    logic [FIFO_PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [FIFO_CNT_W-1:0] cnt_q, cnt_d;
    logic                  do_push, do_pop;

    function automatic logic [FIFO_PTR_W-1:0] ptr_inc(
        input logic [FIFO_PTR_W-1:0] p
    );
        return (p == FIFO_PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + FIFO_PTR_W'(1);
    endfunction

    always_comb begin
        do_pop  = pop_i && (cnt_q != '0);
        do_push = push_i && ((cnt_q != FIFO_CNT_W'(FIFO_DEPTH)) || do_pop);
        wr_d    = do_push ? ptr_inc(wr_q) : wr_q;
        rd_d    = do_pop ? ptr_inc(rd_q) : rd_q;
        cnt_d   = cnt_q;
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + FIFO_CNT_W'(1);
        end else if (!do_push && do_pop) begin
            cnt_d = cnt_q - FIFO_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            if (do_push) begin
                mem_q[wr_q] <= data_i;
            end
        end
    end

    assign valid_o = (cnt_q != '0);
    assign data_o  = valid_o ? mem_q[rd_q] : '0;
    assign count_o = cnt_q;

endmodule

// File: rtl/mem_burst_ctrl.sv
// Burst read/write controller in front of a single-port memory.
// Build option: BURST_WRAP_EN lets bursts wrap from DEPTH-1 to 0.
module mem_burst_ctrl
    import mem_burst_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_wr_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [LEN_WIDTH-1:0]  cmd_len_i,
    input  logic                  wdata_valid_i,
    input  logic [WIDTH-1:0]      wdata_i,
    output logic                  wdata_ready_o,
    output logic                  rdata_valid_o,
    output logic [WIDTH-1:0]      rdata_o,
    input  logic                  rdata_ready_i,
    output logic                  mem_valid_o,
    output logic                  mem_wr_rd_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [WIDTH-1:0]      mem_wr_data_o,
    input  logic [WIDTH-1:0]      mem_rd_data_i,
    input  logic                  mem_ready_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d, addr_inc;
    logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  infl_q, infl_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [FIFO_CNT_W-1:0] fifo_cnt;
    logic                  cmd_fire, cmd_bad, rd_room, last_beat;

    assign cmd_ready_o = (state_q == IDLE) && !rst;
    assign cmd_fire    = cmd_valid_i && cmd_ready_o;
    assign last_beat   = (cnt_q == LEN_WIDTH'(1));
    assign addr_inc    = (addr_q == ADDR_WIDTH'(DEPTH - 1))
                       ? '0 : addr_q + ADDR_WIDTH'(1);
    // Outstanding reads are counted so a returning word always has a slot.
    assign rd_room     = (fifo_cnt + FIFO_CNT_W'(infl_q))
                       < FIFO_CNT_W'(FIFO_DEPTH);

`ifdef BURST_WRAP_EN
    assign cmd_bad = (cmd_len_i == '0)
                   || (cmd_len_i > LEN_WIDTH'(DEPTH));
`else
    logic [LEN_WIDTH:0] end_addr;
    assign end_addr = {1'b0, LEN_WIDTH'(cmd_addr_i)} + {1'b0, cmd_len_i};
    assign cmd_bad  = (cmd_len_i == '0)
                    || (end_addr > (LEN_WIDTH + 1)'(DEPTH));
`endif

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        cnt_d         = cnt_q;
        infl_d        = 1'b0;
        done_d        = 1'b0;
        err_d         = 1'b0;
        wdata_ready_o = 1'b0;
        mem_valid_o   = 1'b0;
        mem_wr_rd_o   = 1'b0;
        mem_addr_o    = '0;
        mem_wr_data_o = '0;
        unique case (state_q)
            IDLE: begin
                if (cmd_fire) begin
                    if (cmd_bad) begin
                        err_d = 1'b1;
                    end else begin
                        addr_d  = cmd_addr_i;
                        cnt_d   = cmd_len_i;
                        state_d = cmd_wr_i ? WR : RD;
                    end
                end
            end
            WR: begin
                mem_valid_o   = wdata_valid_i;
                mem_wr_rd_o   = 1'b1;
                wdata_ready_o = mem_ready_i;
                if (wdata_valid_i) begin
                    mem_addr_o    = addr_q;
                    mem_wr_data_o = wdata_i;
                end
                if (wdata_valid_i && mem_ready_i) begin
                    addr_d = addr_inc;
                    cnt_d  = cnt_q - LEN_WIDTH'(1);
                    if (last_beat) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            RD: begin
                mem_valid_o = rd_room;
                if (rd_room) begin
                    mem_addr_o = addr_q;
                end
                if (rd_room && mem_ready_i) begin
                    infl_d = 1'b1;
                    addr_d = addr_inc;
                    cnt_d  = cnt_q - LEN_WIDTH'(1);
                    if (last_beat) begin
                        state_d = RD_DRAIN;
                    end
                end
            end
            RD_DRAIN: begin
                if (infl_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            infl_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            infl_q  <= infl_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    mem_rd_fifo #(
        .WIDTH(WIDTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push_i (infl_q),
        .data_i (mem_rd_data_i),
        .pop_i  (rdata_ready_i),
        .valid_o(rdata_valid_o),
        .data_o (rdata_o),
        .count_o(fifo_cnt)
    );

    assign busy_o = (state_q != IDLE);
    assign done_o = done_q;
    assign err_o  = err_q;

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Bench for mem_burst_ctrl: burst table plus reset and stall sequences,
// with a memory model and a read-data scoreboard.
module tb_mem_burst_ctrl;

    localparam int W  = 16;
    localparam int D  = 64;
    localparam int AW = 6;
    localparam int LW = 7;
`ifdef BURST_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic          clk, rst;
    logic          cmd_valid_i, cmd_ready_o, cmd_wr_i;
    logic [AW-1:0] cmd_addr_i;
    logic [LW-1:0] cmd_len_i;
    logic          wdata_valid_i, wdata_ready_o;
    logic [W-1:0]  wdata_i;
    logic          rdata_valid_o, rdata_ready_i;
    logic [W-1:0]  rdata_o;
    logic          mem_valid_o, mem_wr_rd_o, mem_ready_i;
    logic [AW-1:0] mem_addr_o;
    logic [W-1:0]  mem_wr_data_o, mem_rd_data_i;
    logic          busy_o, done_o, err_o;

    mem_burst_ctrl #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_wr_i(cmd_wr_i), .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i),
        .wdata_valid_i(wdata_valid_i), .wdata_i(wdata_i),
        .wdata_ready_o(wdata_ready_o),
        .rdata_valid_o(rdata_valid_o), .rdata_o(rdata_o),
        .rdata_ready_i(rdata_ready_i),
        .mem_valid_o(mem_valid_o), .mem_wr_rd_o(mem_wr_rd_o),
        .mem_addr_o(mem_addr_o), .mem_wr_data_o(mem_wr_data_o),
        .mem_rd_data_i(mem_rd_data_i), .mem_ready_i(mem_ready_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    typedef struct {
        bit wr;
        int addr;
        int len;
        int stall;
        bit rnd;
        bit err;
    } vec_t;

    vec_t         vecs[11];
    int           total, bad;
    int           n_done, n_err, n_fire;
    logic [W-1:0] exp_q[$];
    int           log_q[$];
    logic [W-1:0] ref_mem[D];
    logic [W-1:0] mem[D];
    bit           rnd_rdy;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input bit wr, input int a, input int l,
                                input int s, input bit r, input bit e);
        vec_t v;
        v.wr = wr; v.addr = a; v.len = l; v.stall = s; v.rnd = r; v.err = e;
        return v;
    endfunction

    // memory model: read data valid the cycle after an accepted read
    initial begin
        for (int i = 0; i < D; i++) begin
            mem[i] = '0;
            ref_mem[i] = '0;
        end
        mem_rd_data_i = '0;
    end
    always @(posedge clk) begin
        if (mem_valid_o && mem_ready_i) begin
            if (mem_wr_rd_o) mem[mem_addr_o] <= mem_wr_data_o;
            else mem_rd_data_i <= mem[mem_addr_o];
        end
    end

    always @(posedge clk) begin
        #1;
        mem_ready_i = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (done_o) n_done++;
            if (err_o) n_err++;
            if (mem_valid_o && mem_ready_i) begin
                n_fire++;
                log_q.push_back(int'({mem_wr_rd_o, mem_addr_o}));
            end
            if (rdata_valid_o && rdata_ready_i) begin
                if (exp_q.size() == 0) check("rdata_extra", 1, 0);
                else check("rdata", int'(rdata_o), int'(exp_q.pop_front()));
            end
        end
    end

    task automatic run(input vec_t v, input bit now);
        int d0, e0, f0, g;
        logic [W-1:0] wd;
        d0 = n_done; e0 = n_err; f0 = n_fire;
        log_q.delete();
        rnd_rdy = v.rnd;
        if (!v.wr && !v.err)
            for (int i = 0; i < v.len; i++)
                exp_q.push_back(ref_mem[(v.addr + i) % D]);
        if (!now) begin
            @(posedge clk); #1;
        end
        cmd_valid_i = 1'b1;
        cmd_wr_i    = v.wr;
        cmd_addr_i  = AW'(v.addr);
        cmd_len_i   = LW'(v.len);
        @(negedge clk);
        check("cmd_ready", int'(cmd_ready_o), 1);
        @(posedge clk); #1;
        cmd_valid_i = 1'b0;
        if (v.err) begin
            g = 0;
            repeat (4) begin
                @(negedge clk);
                g = g | int'(busy_o);
            end
            check("err_pulse", n_err - e0, 1);
            check("err_busy", g, 0);
            check("err_mem", n_fire - f0, 0);
            check("err_done", n_done - d0, 0);
            rnd_rdy = 1'b0;
            return;
        end
        if (v.wr) begin
            for (int i = 0; i < v.len; i++) begin
                wd = W'($urandom);
                wdata_valid_i = 1'b1;
                wdata_i = wd;
                g = 0;
                @(negedge clk);
                while (!wdata_ready_o && g < 100) begin
                    @(negedge clk);
                    g++;
                end
                if (g >= 100) begin
                    check("wr_timeout", 1, 0);
                    break;
                end
                ref_mem[(v.addr + i) % D] = wd;
                @(posedge clk); #1;
            end
            wdata_valid_i = 1'b0;
        end else if (v.stall > 0) begin
            rdata_ready_i = 1'b0;
            repeat (v.stall) @(posedge clk);
            check("stall_issued_le2", int'((n_fire - f0) <= 2), 1);
            check("stall_hold", int'(rdata_valid_o), 1);
            #1 rdata_ready_i = 1'b1;
        end
        g = 0;
        while (n_done == d0 && g < 3000) begin
            @(negedge clk);
            g++;
        end
        check("done_seen", int'(n_done > d0), 1);
        g = 0;
        while (exp_q.size() != 0 && g < 200) begin
            @(negedge clk);
            g++;
        end
        check("drained", exp_q.size(), 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        check("done_once", n_done - d0, 1);
        check("busy_idle", int'(busy_o), 0);
        check("beats", log_q.size(), v.len);
        for (int i = 0; i < log_q.size() && i < v.len; i++)
            check("addr", log_q[i], (int'(v.wr) << AW) | ((v.addr + i) % D));
        rnd_rdy = 1'b0;
    endtask

    initial begin
        logic [W-1:0] wd;
        total = 0; bad = 0;
        n_done = 0; n_err = 0; n_fire = 0;
        rnd_rdy = 1'b0;
        mem_ready_i = 1'b1;
        rst = 1'b1;
        cmd_valid_i = 1'b0; cmd_wr_i = 1'b0;
        cmd_addr_i = '0; cmd_len_i = '0;
        wdata_valid_i = 1'b0; wdata_i = '0;
        rdata_ready_i = 1'b1;

        vecs[0]  = mk(1'b1, 0, 64, 0, 1'b0, 1'b0);
        vecs[1]  = mk(1'b0, 0, 64, 0, 1'b0, 1'b0);
        vecs[2]  = mk(1'b0, 5, 0, 0, 1'b0, 1'b1);
        vecs[3]  = mk(1'b1, 60, 8, 0, 1'b0, !WRAP);
        vecs[4]  = mk(1'b0, 60, 8, 0, 1'b0, !WRAP);
        vecs[5]  = mk(1'b0, 16, 16, 10, 1'b0, 1'b0);
        vecs[6]  = mk(1'b0, 32, 16, 0, 1'b1, 1'b0);
        vecs[7]  = mk(1'b1, 63, 1, 0, 1'b1, 1'b0);
        vecs[8]  = mk(1'b0, 56, 8, 0, 1'b0, 1'b0);
        vecs[9]  = mk(1'b1, 0, 65, 0, 1'b0, 1'b1);
        vecs[10] = mk(1'b0, 63, 1, 0, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        check("rst_ctl", int'({busy_o, done_o, err_o, cmd_ready_o}), 0);
        check("rst_dp", int'({mem_valid_o, wdata_ready_o, rdata_valid_o}), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rel_ready", int'(cmd_ready_o), 1);
        check("rel_busy", int'(busy_o), 0);

        for (int k = 0; k < 11; k++) run(vecs[k], 1'b0);

        // reset during the fifth write beat
        @(posedge clk); #1;
        cmd_valid_i = 1'b1; cmd_wr_i = 1'b1;
        cmd_addr_i = AW'(8); cmd_len_i = LW'(16);
        @(posedge clk); #1;
        cmd_valid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wd = W'($urandom);
            wdata_valid_i = 1'b1;
            wdata_i = wd;
            @(negedge clk);
            check("pre_rst_ready", int'(wdata_ready_o), 1);
            ref_mem[8 + i] = wd;
            @(posedge clk); #1;
        end
        wdata_i = ~wdata_i;
        @(negedge clk);
        check("beat5_valid", int'(mem_valid_o), 1);
        rst = 1'b1;
        #1;
        check("mid_rst_ctl",
              int'({busy_o, done_o, err_o, cmd_ready_o, wdata_ready_o}), 0);
        check("mid_rst_mem", int'({mem_valid_o, mem_wr_rd_o}), 0);
        check("mid_rst_addr", int'(mem_addr_o), 0);
        check("mid_rst_wdata", int'(mem_wr_data_o), 0);
        check("mid_rst_rd", int'({rdata_valid_o, rdata_o}), 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        wdata_valid_i = 1'b0;
        rst = 1'b0;
        run(mk(1'b0, 8, 4, 0, 1'b0, 1'b0), 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
